// File: rtl/forw_unit_core_pkg.sv
// Shared types for the EX-stage forwarding unit: opcodes, select codes,
// port bundles and the select-is-forwarding helper.
package forw_unit_core_pkg;

    localparam int FW_DW  = 32;
    localparam int FW_OPW = 7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic              isForw_ON;
        logic [FW_OPW-1:0] op;
        logic [FW_DW-1:0]  exmem_result;
        logic [FW_DW-1:0]  memwb_result;
        logic [1:0]        forwA;
        logic [1:0]        forwB;
        logic [FW_DW-1:0]  data1;
        logic [FW_DW-1:0]  data2;
        logic [FW_DW-1:0]  s_data;
    } forw_in_t;

    typedef struct packed {
        logic [FW_DW-1:0] operand1;
        logic [FW_DW-1:0] operand2;
        logic [FW_DW-1:0] sData;
    } forw_out_t;

    // Reserved code 11 selects the register value, same as 00.
    function automatic logic sel_is_fwd(input logic [1:0] sel);
        return (sel == FWD_EXMEM) || (sel == FWD_MEMWB);
    endfunction

endpackage

// File: rtl/forw_unit_core_mux3.sv
// forw_mux3: combinational 3:1 forwarding select.
// Ports: sel_i (select code), reg_i/exmem_i/memwb_i (sources), y_o (result).
module forw_mux3
    import forw_unit_core_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] reg_i,
    input  logic [W-1:0] exmem_i,
    input  logic [W-1:0] memwb_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = reg_i;
        unique case (1'b1)
            (sel_i == FWD_EXMEM): y_o = exmem_i;
            (sel_i == FWD_MEMWB): y_o = memwb_i;
            default:              y_o = reg_i;
        endcase
    end

endmodule

// File: rtl/forw_unit_core.sv
// EX-stage operand forwarding unit with registered ALU operands and store data.
// Inputs: clk, rst (async active-low), isForw_ON, op, exmem_result, memwb_result,
// forwA, forwB, data1, data2, s_data. Outputs: operand1, operand2, sData.
// Define FORW_STATS_EN to add cntA_exmem, cntA_memwb and cntB_fwd counters.
module forw_unit_core
    import forw_unit_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  isForw_ON,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    input  logic [1:0]            forwA,
    input  logic [1:0]            forwB,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic [DATA_WIDTH-1:0] data2,
    input  logic [DATA_WIDTH-1:0] s_data,
`ifdef FORW_STATS_EN
    output logic [31:0]           cntA_exmem,
    output logic [31:0]           cntA_memwb,
    output logic [31:0]           cntB_fwd,
`endif
    output logic [DATA_WIDTH-1:0] operand1,
    output logic [DATA_WIDTH-1:0] operand2,
    output logic [DATA_WIDTH-1:0] sData
);

    logic [DATA_WIDTH-1:0] fwd_a, fwd_b, fwd_s;
    logic [DATA_WIDTH-1:0] op1_d, op2_d, sd_d;
    logic [DATA_WIDTH-1:0] op1_q, op2_q, sd_q;
    logic use_a, use_b, use_s;

    forw_mux3 #(.W(DATA_WIDTH)) u_mux_a (
        .sel_i   (forwA),
        .reg_i   (data1),
        .exmem_i (exmem_result),
        .memwb_i (memwb_result),
        .y_o     (fwd_a)
    );

    forw_mux3 #(.W(DATA_WIDTH)) u_mux_b (
        .sel_i   (forwB),
        .reg_i   (data2),
        .exmem_i (exmem_result),
        .memwb_i (memwb_result),
        .y_o     (fwd_b)
    );

    forw_mux3 #(.W(DATA_WIDTH)) u_mux_s (
        .sel_i   (forwB),
        .reg_i   (s_data),
        .exmem_i (exmem_result),
        .memwb_i (memwb_result),
        .y_o     (fwd_s)
    );

    // Operand A of LUI/AUIPC/JAL does not come from rs1, so never forward it.
    // Operand B only carries rs2 for R-type and branches; others use the imm.
    always_comb begin
        use_a = isForw_ON && (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
        use_b = isForw_ON && ((op == OP_R) || (op == OP_BRANCH));
        use_s = isForw_ON && (op == OP_STORE);
        op1_d = use_a ? fwd_a : data1;
        op2_d = use_b ? fwd_b : data2;
        sd_d  = use_s ? fwd_s : s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op1_q <= '0;
            op2_q <= '0;
            sd_q  <= '0;
        end else begin
            op1_q <= op1_d;
            op2_q <= op2_d;
            sd_q  <= sd_d;
        end
    end

    assign operand1 = op1_q;
    assign operand2 = op2_q;
    assign sData    = sd_q;

`ifdef FORW_STATS_EN
    logic [31:0] cnt_ae_q, cnt_am_q, cnt_b_q;
    logic        inc_ae, inc_am, inc_b;

    always_comb begin
        inc_ae = use_a && (forwA == FWD_EXMEM);
        inc_am = use_a && (forwA == FWD_MEMWB);
        inc_b  = (use_b || use_s) && sel_is_fwd(forwB);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_ae_q <= '0;
            cnt_am_q <= '0;
            cnt_b_q  <= '0;
        end else begin
            if (inc_ae) cnt_ae_q <= cnt_ae_q + 32'd1;
            if (inc_am) cnt_am_q <= cnt_am_q + 32'd1;
            if (inc_b)  cnt_b_q  <= cnt_b_q + 32'd1;
        end
    end

    assign cntA_exmem = cnt_ae_q;
    assign cntA_memwb = cnt_am_q;
    assign cntB_fwd   = cnt_b_q;
`endif

endmodule

// File: tb/tb_forw_unit_core.sv
// Directed and swept vectors for forw_unit_core against a small reference model.
// Checks reset, forwarding per opcode class, bypass, reserved select and opcode masking.
module tb_forw_unit_core;
    import forw_unit_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    forw_in_t    v;
    logic [31:0] operand1, operand2, sData;
    int          n_tests = 0;
    int          n_fail  = 0;

`ifdef FORW_STATS_EN
    logic [31:0] cntA_exmem, cntA_memwb, cntB_fwd;
`endif

    always #5 clk = ~clk;

    forw_unit_core #(.DATA_WIDTH(32), .OP_WIDTH(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .isForw_ON    (v.isForw_ON),
        .op           (v.op),
        .exmem_result (v.exmem_result),
        .memwb_result (v.memwb_result),
        .forwA        (v.forwA),
        .forwB        (v.forwB),
        .data1        (v.data1),
        .data2        (v.data2),
        .s_data       (v.s_data),
`ifdef FORW_STATS_EN
        .cntA_exmem   (cntA_exmem),
        .cntA_memwb   (cntA_memwb),
        .cntB_fwd     (cntB_fwd),
`endif
        .operand1     (operand1),
        .operand2     (operand2),
        .sData        (sData)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s,
                                         input logic [31:0] r,
                                         input forw_in_t x);
        case (s)
            2'b01:   return x.exmem_result;
            2'b10:   return x.memwb_result;
            default: return r;
        endcase
    endfunction

    function automatic forw_out_t model(input forw_in_t x);
        forw_out_t o;
        o.operand1 = x.data1;
        o.operand2 = x.data2;
        o.sData    = x.s_data;
        if (x.isForw_ON) begin
            case (x.op)
                7'b0110111, 7'b0010111, 7'b1101111: ;
                default: o.operand1 = pick(x.forwA, x.data1, x);
            endcase
            case (x.op)
                7'b0110011, 7'b1100011: o.operand2 = pick(x.forwB, x.data2, x);
                default: ;
            endcase
            if (x.op == 7'b0100011)
                o.sData = pick(x.forwB, x.s_data, x);
        end
        return o;
    endfunction

    task automatic step(input forw_in_t x);
        v = x;
        @(posedge clk);
        #1;
    endtask

    forw_in_t  base;
    forw_in_t  t;
    forw_out_t e;
    logic [6:0] ops [10];

    initial begin
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b0001111};
        v   = '0;
        rst = 1'b0;
        #3;
        chk("rst_op1", operand1, 32'h0);
        chk("rst_op2", operand2, 32'h0);
        chk("rst_sd", sData, 32'h0);
        rst = 1'b1;

        base = '0;
        base.isForw_ON    = 1'b1;
        base.op           = 7'b0110011;
        base.forwA        = 2'b01;
        base.forwB        = 2'b10;
        base.data1        = 32'h11;
        base.data2        = 32'h22;
        base.s_data       = 32'h77;
        base.exmem_result = 32'hAAAA_0001;
        base.memwb_result = 32'hBBBB_0002;
        step(base);
        chk("r_op1", operand1, 32'hAAAA_0001);
        chk("r_op2", operand2, 32'hBBBB_0002);
        chk("r_sd", sData, 32'h77);

        t = base;
        t.isForw_ON = 1'b0;
        step(t);
        chk("off_op1", operand1, 32'h11);
        chk("off_op2", operand2, 32'h22);
        chk("off_sd", sData, 32'h77);

        t = base;
        t.op           = 7'b0100011;
        t.forwA        = 2'b00;
        t.forwB        = 2'b01;
        t.data1        = 32'h33;
        t.data2        = 32'h8;
        t.s_data       = 32'h55;
        t.exmem_result = 32'hDEAD_BEEF;
        step(t);
        chk("st_op1", operand1, 32'h33);
        chk("st_op2", operand2, 32'h8);
        chk("st_sd", sData, 32'hDEAD_BEEF);

        t = base;
        t.op = 7'b0110111;
        step(t);
        chk("lui_op1", operand1, 32'h11);
        chk("lui_op2", operand2, 32'h22);

        t = base;
        t.forwA = 2'b11;
        t.forwB = 2'b11;
        step(t);
        chk("rsv_op1", operand1, 32'h11);
        chk("rsv_op2", operand2, 32'h22);

        // Select change between edges must not reach the outputs.
        t.forwA = 2'b01;
        v = t;
        #2;
        chk("noclk_op1", operand1, 32'h11);

        for (int i = 0; i < 160; i++) begin
            t = '0;
            t.isForw_ON    = (i % 7 != 3);
            t.op           = ops[(i / 16) % 10];
            t.forwA        = 2'(i % 4);
            t.forwB        = 2'((i / 4) % 4);
            t.data1        = $urandom;
            t.data2        = $urandom;
            t.s_data       = $urandom;
            t.exmem_result = $urandom;
            t.memwb_result = $urandom;
            e = model(t);
            step(t);
            chk("sw_op1", operand1, e.operand1);
            chk("sw_op2", operand2, e.operand2);
            chk("sw_sd", sData, e.sData);
        end

        v = base;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_op1", operand1, 32'h0);
        chk("arst_op2", operand2, 32'h0);
        chk("arst_sd", sData, 32'h0);
`ifdef FORW_STATS_EN
        chk("arst_cnt", cntA_exmem, 32'h0);
`endif
        @(posedge clk);
        #1;
        chk("hold_op1", operand1, 32'h0);
        rst = 1'b1;
        step(base);
        chk("rel_op1", operand1, 32'hAAAA_0001);
`ifdef FORW_STATS_EN
        chk("cnt_ae", cntA_exmem, 32'h1);
        chk("cnt_b", cntB_fwd, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
